// File: rtl/usb_tx_pkg.sv
// Shared types for the USB FS/LS transmit line encoder.
// Line symbols are kept abstract (J/K/SE0) and mapped to pad levels at the output.
package usb_tx_pkg;

  typedef enum logic [1:0] {IDLE, DATA, EOP_SE0, EOP_J} state_t;
  typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0} line_t;

  // Low speed swaps J/K polarity: J is D- high.
  function automatic logic [1:0] line_pins(line_t l, bit low_speed);
    case (l)
      LINE_J:  return low_speed ? 2'b01 : 2'b10;
      LINE_K:  return low_speed ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_line_encoder_timer.sv
// Bit-slot timer: counts system clocks within one USB bit slot and flags the
// final clock of the slot.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_slot_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] r_bit_cnt;

  assign o_slot_end = (r_bit_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_bit_cnt <= '0;
    else if (i_clr)      r_bit_cnt <= '0;
    else if (i_en)       r_bit_cnt <= o_slot_end ? '0 : r_bit_cnt + 1'b1;
  end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB FS/LS line driver: NRZI encoding, bit stuffing and EOP generation
// behind a one-bit valid/ready stream interface.
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2,
  parameter int LOW_SPEED    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tx_valid,
  input  logic i_tx_data,
  input  logic i_tx_last,
  output logic o_tx_ready,
  output logic o_d_plus,
  output logic o_d_minus,
  output logic o_tx_oe,
  output logic o_tx_busy,
  output logic o_tx_error
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int EW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);
  localparam logic [EW-1:0] SE0_LAST = EW'(EOP_SE0_BITS - 1);

  state_t        r_state;
  line_t         r_line;
  logic          r_oe;
  logic          r_err;
  logic          r_last;
  logic [OW-1:0] r_ones;
  logic [EW-1:0] r_eop_cnt;

  logic  w_slot_end;
  logic  w_stuff;
  logic  w_ready;
  logic  w_xfer;
  line_t w_toggled;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_state != IDLE),
    .i_clr      (r_state == IDLE),
    .o_slot_end (w_slot_end)
  );

  assign w_stuff   = (r_ones == ONES_MAX);
  assign w_toggled = (r_line == LINE_J) ? LINE_K : LINE_J;
  assign w_ready   = (r_state == IDLE) |
                     ((r_state == DATA) & w_slot_end & ~w_stuff & ~r_last);
  assign w_xfer    = i_tx_valid & w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_line    <= LINE_J;
      r_oe      <= 1'b0;
      r_err     <= 1'b0;
      r_last    <= 1'b0;
      r_ones    <= '0;
      r_eop_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (w_xfer) begin
          r_state <= DATA;
          r_oe    <= 1'b1;
          r_line  <= i_tx_data ? r_line : w_toggled;
          r_ones  <= OW'(i_tx_data);
          r_last  <= i_tx_last;
        end
        DATA: if (w_slot_end) begin
          // Stuffing outranks end-of-packet so a run of ones on the last bit is still broken.
          if (w_stuff) begin
            r_line <= w_toggled;
            r_ones <= '0;
          end else if (r_last) begin
            r_state   <= EOP_SE0;
            r_line    <= LINE_SE0;
            r_eop_cnt <= '0;
          end else if (i_tx_valid) begin
            if (i_tx_data) r_ones <= r_ones + 1'b1;
            else begin
              r_line <= w_toggled;
              r_ones <= '0;
            end
            r_last <= i_tx_last;
          end else begin
            r_err     <= 1'b1;
            r_state   <= EOP_SE0;
            r_line    <= LINE_SE0;
            r_eop_cnt <= '0;
          end
        end
        EOP_SE0: if (w_slot_end) begin
          if (r_eop_cnt == SE0_LAST) begin
            r_state <= EOP_J;
            r_line  <= LINE_J;
          end else begin
            r_eop_cnt <= r_eop_cnt + 1'b1;
          end
        end
        EOP_J: if (w_slot_end) begin
          r_state <= IDLE;
          r_oe    <= 1'b0;
          r_ones  <= '0;
          r_last  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign {o_d_plus, o_d_minus} = line_pins(r_line, LOW_SPEED != 0);
  assign o_tx_ready = w_ready;
  assign o_tx_oe    = r_oe;
  assign o_tx_busy  = (r_state != IDLE);
  assign o_tx_error = r_err;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Bench for usb_tx_line_encoder: a symbol-level model expands each packet into
// per-cycle expected pad/handshake values, compared every cycle at negedge.
module tb_usb_tx_line_encoder;

  localparam int FS_CPB = 4;
  localparam int LS_CPB = 32;
  localparam int STUFF  = 6;

  logic clk = 1'b0;
  logic rst;
  logic valid, data, last, sel_ls;

  always #5 clk = ~clk;

  logic f_rdy, f_dp, f_dm, f_oe, f_busy, f_err;
  logic l_rdy, l_dp, l_dm, l_oe, l_busy, l_err;
  logic m_rdy, m_dp, m_dm, m_oe, m_busy, m_err;

  usb_tx_line_encoder #(.CLKS_PER_BIT(FS_CPB), .STUFF_LIMIT(STUFF), .EOP_SE0_BITS(2), .LOW_SPEED(0)) u_fs (
    .clk(clk), .rst(rst),
    .i_tx_valid(valid & ~sel_ls), .i_tx_data(data), .i_tx_last(last),
    .o_tx_ready(f_rdy), .o_d_plus(f_dp), .o_d_minus(f_dm),
    .o_tx_oe(f_oe), .o_tx_busy(f_busy), .o_tx_error(f_err)
  );

  usb_tx_line_encoder #(.CLKS_PER_BIT(LS_CPB), .STUFF_LIMIT(STUFF), .EOP_SE0_BITS(2), .LOW_SPEED(1)) u_ls (
    .clk(clk), .rst(rst),
    .i_tx_valid(valid & sel_ls), .i_tx_data(data), .i_tx_last(last),
    .o_tx_ready(l_rdy), .o_d_plus(l_dp), .o_d_minus(l_dm),
    .o_tx_oe(l_oe), .o_tx_busy(l_busy), .o_tx_error(l_err)
  );

  assign m_rdy  = sel_ls ? l_rdy  : f_rdy;
  assign m_dp   = sel_ls ? l_dp   : f_dp;
  assign m_dm   = sel_ls ? l_dm   : f_dm;
  assign m_oe   = sel_ls ? l_oe   : f_oe;
  assign m_busy = sel_ls ? l_busy : f_busy;
  assign m_err  = sel_ls ? l_err  : f_err;

  typedef struct packed {logic oe, dp, dm, busy, err, rdy;} exp_t;
  typedef struct {int line; bit req;} sym_t;  // line: 0=J 1=K 2=SE0; req: slot consumes an input bit

  sym_t syms[$];
  exp_t mq[$];
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [1:0] pins(int line, bit ls);
    if (line == 2) return 2'b00;
    return ((line == 0) ^ ls) ? 2'b10 : 2'b01;
  endfunction

  // Symbol list from the protocol rules, then one expected entry per clock.
  task automatic build_model(input logic [63:0] bits, input int n, input int u, input bit ls, input int cpb);
    int line = 0;
    int ones = 0;
    int se0_at = -1;
    exp_t e;
    syms.delete();
    mq.delete();
    for (int i = 0; i < n; i++) begin
      if (i == u) break;
      if (bits[i] == 1'b0) begin line = 1 - line; ones = 0; end
      else ones++;
      syms.push_back('{line, 1'b1});
      if (ones == STUFF) begin
        line = 1 - line; ones = 0;
        syms.push_back('{line, 1'b0});
      end
    end
    if (u >= 0 && u < n) begin
      se0_at = syms.size();
      syms.push_back('{2, 1'b1});
    end else begin
      syms.push_back('{2, 1'b0});
    end
    syms.push_back('{2, 1'b0});
    syms.push_back('{0, 1'b0});
    for (int s = 0; s < syms.size(); s++) begin
      for (int c = 0; c < cpb; c++) begin
        e.oe = 1'b1;
        {e.dp, e.dm} = pins(syms[s].line, ls);
        e.busy = 1'b1;
        e.err = (s == se0_at) && (c == 0);
        e.rdy = (c == cpb - 1) && (s + 1 < syms.size()) && syms[s + 1].req;
        mq.push_back(e);
      end
    end
    e.oe = 1'b0;
    {e.dp, e.dm} = pins(0, ls);
    e.busy = 1'b0;
    e.err = 1'b0;
    e.rdy = 1'b1;
    mq.push_back(e);
  endtask

  // Streams bits[0..n-1] (valid dropped from index u on), arming the compare at first transfer.
  task automatic run_packet(input logic [63:0] bits, input int n, input int u);
    int idx = 0;
    int cyc = 0;
    bit started = 0;
    bit done = 0;
    bit wx;
    @(posedge clk); #1;
    while (cyc < 3000 && !done) begin
      valid = (idx < n) && (idx != u);
      data  = (idx < n) ? bits[idx] : 1'b0;
      last  = (idx == n - 1);
      wx = valid & m_rdy;
      @(posedge clk); #1;
      if (wx) begin
        idx++;
        if (!started) begin started = 1; exp_q = mq; end
      end
      if (started && exp_q.size() == 0) done = 1;
      cyc++;
    end
    valid = 1'b0;
    chk("pkt_complete", {31'd0, done}, 32'd1);
    if (!done) exp_q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {m_oe, m_dp, m_dm, m_busy, m_err, m_rdy};
      chk("cycle{oe,dp,dm,busy,err,rdy}", {26'd0, a}, {26'd0, e});
    end
  end

  initial begin
    logic [7:0] v;
    int nerr;
    rst = 1'b1; valid = 1'b0; data = 1'b0; last = 1'b0; sel_ls = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fs", {f_dp, f_dm, f_oe, f_busy, f_err, f_rdy}, 6'b100001);
    chk("rst_ls", {l_dp, l_dm, l_oe, l_busy, l_err}, 5'b01000);
    @(negedge clk) rst = 1'b0;

    // 1: sync pattern
    build_model(64'h80, 8, -1, 1'b0, FS_CPB);
    chk("m1_len", syms.size(), 11);
    for (int i = 0; i < 8; i++) v[i] = (syms[i].line == 1);
    chk("m1_nrzi", v, 8'b1101_0101);
    run_packet(64'h80, 8, -1);
    chk("t1_idle", {f_oe, f_busy, f_dp, f_dm}, 4'b0010);

    // 2: stuffing after six ones
    build_model(64'hFE, 8, -1, 1'b0, FS_CPB);
    chk("m2_len", syms.size(), 12);
    chk("m2_stuff_line", syms[7].line, 0);
    chk("m2_stuff_req", {31'd0, syms[7].req}, 0);
    chk("m2_after_line", syms[8].line, 0);
    run_packet(64'hFE, 8, -1);

    // 3: stuff on the last bit
    build_model(64'h3F, 6, -1, 1'b0, FS_CPB);
    chk("m3_len", syms.size(), 10);
    chk("m3_stuff_line", syms[6].line, 1);
    chk("m3_se0", syms[7].line, 2);
    run_packet(64'h3F, 6, -1);

    // 4: underrun after three bits
    build_model(64'h02, 6, 3, 1'b0, FS_CPB);
    chk("m4_len", syms.size(), 6);
    nerr = 0;
    foreach (mq[i]) if (mq[i].err) nerr++;
    chk("m4_err_cycles", nerr, 1);
    run_packet(64'h02, 6, 3);

    // 5: reset mid-packet (K, K, K line with ones run building)
    @(posedge clk); #1;
    valid = 1'b1; data = 1'b0; last = 1'b0;
    @(posedge clk); #1;
    data = 1'b1;
    chk("t5_first_k", {f_dp, f_dm, f_oe}, 3'b011);
    repeat (8) @(posedge clk);
    #1;
    chk("t5_slot3", {f_dp, f_dm, f_oe, f_busy}, 4'b0111);
    rst = 1'b1; valid = 1'b0;
    #1;
    chk("t5_async", {f_dp, f_dm, f_oe, f_busy, f_rdy}, 5'b10001);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("t5_ready", {31'd0, f_rdy}, 1);
    build_model(64'h1F, 6, -1, 1'b0, FS_CPB);
    chk("m5_len", syms.size(), 9);
    run_packet(64'h1F, 6, -1);

    // 6: low speed sync pattern
    sel_ls = 1'b1;
    build_model(64'h80, 8, -1, 1'b1, LS_CPB);
    chk("m6_len", mq.size(), 11 * LS_CPB + 1);
    chk("m6_first_k", {mq[0].dp, mq[0].dm}, 2'b10);
    run_packet(64'h80, 8, -1);
    chk("t6_idle", {l_oe, l_busy, l_dp, l_dm}, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
